handshake_const_arbiter: RTL and testbench

HANDSHAKE_CONST_ARBITER -- requirements
Module: handshake_const_arbiter

---
 rtl/handshake_const_arbiter.sv | 146 ++++++++++++++
 tb/tb_handshake_const_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_const_arbiter.sv
// -----------------------------------------------------------------------------
// handshake_const_arbiter
//
// Purpose:
//   Several requesters share one constant-token source. Each requester offers a
//   dataless control token with a valid/ready handshake. A round-robin arbiter
//   picks one of them whenever the single registered output slot can take a
//   token. The accepted token leaves on the output channel as CONST_VALUE,
//   tagged with the index of the requester that produced it.
//
//   The output slot is fully registered. There is no combinational path from
//   ins_valid to outs / outs_index / outs_valid. A drain and a reload can
//   happen on the same edge, so a continuously ready consumer sees one token
//   per cycle.
//
// Parameters:
//   DATA_WIDTH   width of the constant output token
//   NUM_REQ      number of requesters (2..16)
//   INDEX_WIDTH  width of the granted-requester index (2**INDEX_WIDTH >= NUM_REQ)
//   CONST_VALUE  value driven on outs with every emitted token
//
// Ports:
//   clk         in   sole clock, rising edge
//   rst         in   synchronous, active-high reset
//   ins_valid   in   [NUM_REQ]      per-requester token valid
//   ins_ready   out  [NUM_REQ]      per-requester token accept (at most one hot)
//   outs        out  [DATA_WIDTH]   constant token data
//   outs_index  out  [INDEX_WIDTH]  requester that produced the current token
//   outs_valid  out                 output token valid
//   outs_ready  in                  downstream accept
// -----------------------------------------------------------------------------
module handshake_const_arbiter #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REQ     = 4,
  parameter int                    INDEX_WIDTH = 2,
  parameter logic [DATA_WIDTH-1:0] CONST_VALUE = DATA_WIDTH'(1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     ins_valid,
  output logic [NUM_REQ-1:0]     ins_ready,
  output logic [DATA_WIDTH-1:0]  outs,
  output logic [INDEX_WIDTH-1:0] outs_index,
  output logic                   outs_valid,
  input  logic                   outs_ready
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]  outs_q,       outs_d;
  logic [INDEX_WIDTH-1:0] outs_index_q, outs_index_d;
  logic                   outs_valid_q, outs_valid_d;
  // Requester that gets first look in the next arbitration round.
  logic [INDEX_WIDTH-1:0] ptr_q,        ptr_d;

  // ---------------------------------------------------------------------------
  // Round-robin winner search
  // ---------------------------------------------------------------------------
  logic                   win_found;
  logic [INDEX_WIDTH-1:0] win_idx;
  logic [INDEX_WIDTH-1:0] cand;

  // NOTE: every signal driven from always_comb gets a default at the top of
  // the block. If a path leaves a signal unassigned, synthesis infers a latch.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    // Walk ptr, ptr+1, ... (mod NUM_REQ). The first valid requester wins.
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = INDEX_WIDTH'((int'(ptr_q) + k) % NUM_REQ);
      if (!win_found && ins_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic slot_avail;
  logic grant;
  logic drain;

  // The slot can take a token when it is empty, or when it is being emptied on
  // this same edge.
  assign slot_avail = !outs_valid_q || outs_ready;
  assign drain      = outs_valid_q && outs_ready;
  // Reset gates the grant so that no requester sees ready while rst is high.
  assign grant      = win_found && slot_avail && !rst;

  always_comb begin
    ins_ready = '0;
    if (grant) begin
      ins_ready[win_idx] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    outs_d       = outs_q;
    outs_index_d = outs_index_q;
    outs_valid_d = outs_valid_q;
    ptr_d        = ptr_q;

    if (grant) begin
      // Reload takes priority over drain, so back-to-back tokens leave no bubble.
      outs_d       = CONST_VALUE;
      outs_index_d = win_idx;
      outs_valid_d = 1'b1;
      ptr_d        = (win_idx == INDEX_WIDTH'(NUM_REQ - 1))
                       ? '0 : win_idx + INDEX_WIDTH'(1);
    end else if (drain) begin
      // Data and index keep their last values; only valid drops.
      outs_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together from the values held before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      outs_q       <= '0;
      outs_index_q <= '0;
      outs_valid_q <= 1'b0;
      ptr_q        <= '0;
    end else begin
      outs_q       <= outs_d;
      outs_index_q <= outs_index_d;
      outs_valid_q <= outs_valid_d;
      ptr_q        <= ptr_d;
    end
  end

  assign outs       = outs_q;
  assign outs_index = outs_index_q;
  assign outs_valid = outs_valid_q;

endmodule

// File: tb/tb_handshake_const_arbiter.sv
// -----------------------------------------------------------------------------
// tb_handshake_const_arbiter
//
// Directed stimulus for handshake_const_arbiter with a behavioural model.
// The model holds the arbitration pointer and the output slot as plain
// integers. A compare process checks the DUT against the model on every
// falling edge. Each directed scenario also checks hand-computed grant
// sequences and output values.
// -----------------------------------------------------------------------------
module tb_handshake_const_arbiter;

  localparam int          DATA_WIDTH  = 32;
  localparam int          NUM_REQ     = 4;
  localparam int          INDEX_WIDTH = 2;
  localparam logic [31:0] CONST_VALUE = 32'd1;

  logic                   clk;
  logic                   rst;
  logic [NUM_REQ-1:0]     ins_valid;
  logic [NUM_REQ-1:0]     ins_ready;
  logic [DATA_WIDTH-1:0]  outs;
  logic [INDEX_WIDTH-1:0] outs_index;
  logic                   outs_valid;
  logic                   outs_ready;

  handshake_const_arbiter #(
    .DATA_WIDTH  (DATA_WIDTH),
    .NUM_REQ     (NUM_REQ),
    .INDEX_WIDTH (INDEX_WIDTH),
    .CONST_VALUE (CONST_VALUE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .outs       (outs),
    .outs_index (outs_index),
    .outs_valid (outs_valid),
    .outs_ready (outs_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic        m_valid = 1'b0;
  logic [31:0] m_data  = '0;
  int          m_idx   = 0;
  int          m_ptr   = 0;

  // Winner in this cycle, or -1 when nobody wins.
  int          grant_log[$];

  function automatic int winner(input logic [NUM_REQ-1:0] v, input int p);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    end
    return -1;
  endfunction

  int                 exp_win;
  logic               exp_grant;
  logic [NUM_REQ-1:0] exp_ready;

  always_comb begin
    exp_win   = -1;
    exp_grant = 1'b0;
    exp_ready = '0;
    if (!rst) exp_win = winner(ins_valid, m_ptr);
    exp_grant = (exp_win >= 0) && (!m_valid || outs_ready);
    if (exp_grant) exp_ready = NUM_REQ'(1 << exp_win);
  end

  // Compare process: inputs change just after each rising edge, so the
  // falling edge sees settled inputs and outputs.
  always @(negedge clk) begin
    check("ins_ready",  32'(ins_ready),  32'(exp_ready));
    check("outs_valid", 32'(outs_valid), 32'(m_valid));
    check("outs",       outs,            m_data);
    check("outs_index", 32'(outs_index), 32'(m_idx));
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_idx   <= 0;
      m_ptr   <= 0;
    end else if (exp_grant) begin
      m_valid <= 1'b1;
      m_data  <= CONST_VALUE;
      m_idx   <= exp_win;
      m_ptr   <= (exp_win + 1) % NUM_REQ;
    end else if (m_valid && outs_ready) begin
      m_valid <= 1'b0;
    end
    grant_log.push_back(exp_grant ? exp_win : -1);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  int exp_q[$];

  // Hold the inputs for one full cycle, then return just after the rising edge.
  task automatic drive(input logic [NUM_REQ-1:0] v, input logic r, input logic rs);
    ins_valid  = v;
    outs_ready = r;
    rst        = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic check_log(input string name);
    check({name, "_len"}, 32'(grant_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < grant_log.size(); i++) begin
      check(name, 32'(grant_log[i]), 32'(exp_q[i]));
    end
  endtask

  logic [NUM_REQ-1:0] pat_v [8] = '{4'b1010, 4'b1010, 4'b0110, 4'b1111,
                                    4'b0001, 4'b0001, 4'b1000, 4'b0000};
  logic               pat_r [8] = '{1'b1, 1'b0, 1'b1, 1'b1,
                                    1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    rst        = 1'b1;
    ins_valid  = '0;
    outs_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset state.
    drive(4'b1111, 1'b1, 1'b1);
    drive(4'b1111, 1'b1, 1'b1);
    check("rst_valid", 32'(outs_valid), 32'd0);
    check("rst_outs",  outs,            32'd0);
    check("rst_index", 32'(outs_index), 32'd0);

    // All requesters valid: strict rotation with no bubbles.
    grant_log.delete();
    for (int i = 0; i < 8; i++) begin
      drive(4'b1111, 1'b1, 1'b0);
      check("rr_valid", 32'(outs_valid), 32'd1);
      check("rr_outs",  outs,            32'd1);
      check("rr_index", 32'(outs_index), 32'(i % 4));
    end
    exp_q = '{0, 1, 2, 3, 0, 1, 2, 3};
    check_log("rr_grants");

    // Drain with no grant: valid drops, data and index hold.
    drive(4'b0000, 1'b1, 1'b0);
    check("drain_valid", 32'(outs_valid), 32'd0);
    check("drain_index", 32'(outs_index), 32'd3);
    check("drain_outs",  outs,            32'd1);

    // Single requester is granted every cycle.
    grant_log.delete();
    for (int i = 0; i < 4; i++) begin
      drive(4'b0100, 1'b1, 1'b0);
      check("single_index", 32'(outs_index), 32'd2);
    end
    exp_q = '{2, 2, 2, 2};
    check_log("single_grants");

    // Wrap-around: the pointer is 3 here.
    grant_log.delete();
    drive(4'b1001, 1'b1, 1'b0);
    drive(4'b1001, 1'b1, 1'b0);
    drive(4'b1001, 1'b1, 1'b0);
    exp_q = '{3, 0, 3};
    check_log("wrap_grants");

    // Backpressure: grant requester 1, then stall.
    drive(4'b0010, 1'b1, 1'b0);
    grant_log.delete();
    for (int i = 0; i < 5; i++) begin
      drive(4'b1111, 1'b0, 1'b0);
      check("stall_index", 32'(outs_index), 32'd1);
      check("stall_valid", 32'(outs_valid), 32'd1);
    end
    exp_q = '{-1, -1, -1, -1, -1};
    check_log("stall_grants");
    grant_log.delete();
    drive(4'b1111, 1'b1, 1'b0);
    exp_q = '{2};
    check_log("unstall_grant");
    check("unstall_index", 32'(outs_index), 32'd2);

    // Reset in the middle of a stall discards the held token.
    drive(4'b1111, 1'b0, 1'b0);
    grant_log.delete();
    drive(4'b1111, 1'b0, 1'b1);
    check("midrst_valid", 32'(outs_valid), 32'd0);
    check("midrst_index", 32'(outs_index), 32'd0);
    check("midrst_outs",  outs,            32'd0);
    drive(4'b1111, 1'b1, 1'b0);
    exp_q = '{-1, 0};
    check_log("midrst_grants");

    // Idle with outs_ready toggling: no grants, and the pointer stays at 1.
    grant_log.delete();
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      drive(4'b0000, 1'(i % 2), 1'b0);
      exp_q.push_back(-1);
    end
    check_log("idle_grants");
    check("idle_valid", 32'(outs_valid), 32'd0);
    grant_log.delete();
    drive(4'b1111, 1'b1, 1'b0);
    exp_q = '{1};
    check_log("post_idle_grant");
    check("post_idle_index", 32'(outs_index), 32'd1);

    // Mixed patterns are checked by the model alone.
    for (int i = 0; i < 8; i++) begin
      drive(pat_v[i], pat_r[i], 1'b0);
    end
    drive(4'b0000, 1'b1, 1'b0);
    drive(4'b0000, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
